// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared constants and FSM state type for the AES-128 stream front end
package aes128_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_TEXT = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DRAIN     = 3'd5
    } aes_sc_state_e;

endpackage

// File: rtl/aes128_word_packer.sv
// rtl/aes128_word_packer.sv - gathers four 32-bit words into one 128-bit block, first word at the top
module aes128_word_packer
    import aes128_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [AES_WORD_W-1:0]  data,
    output logic [AES_BLOCK_W-1:0] block,
    output logic                   full
);

    logic [1:0] count;

    // Words enter at the bottom and move up, so the first word ends in bits [127:96]
    always_ff @(posedge clk) begin
        if (rst) begin
            block <= '0;
            count <= '0;
        end else begin
            if (shift) begin
                block <= {block[AES_BLOCK_W-AES_WORD_W-1:0], data};
            end
            if (clear) begin
                count <= '0;
            end else if (shift) begin
                count <= count + 2'd1;
            end
        end
    end

    // High in the cycle the last word of a block is accepted
    assign full = shift && (count == 2'(AES_WORDS - 1));

endmodule

// File: rtl/aes128_stream_ctrl.sv
// rtl/aes128_stream_ctrl.sv - word-serial command/key/text front end and result drain for aes128_core
module aes128_stream_ctrl
    import aes128_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_dec_i,
    input  logic                   cmd_key_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic                   out_last_o,
    output logic                   aes_start_enc_o,
    output logic                   aes_start_dec_o,
    output logic [AES_BLOCK_W-1:0] aes_key_o,
    output logic [AES_BLOCK_W-1:0] aes_text_o,
    input  logic                   aes_ready_i,
    input  logic                   aes_done_i,
    input  logic [AES_BLOCK_W-1:0] aes_text_i,
    output logic                   busy_o,
    output logic                   err_o
);

    aes_sc_state_e          state;
    aes_sc_state_e          state_next;
    logic                   dir;
    logic                   key_valid;
    logic                   err_q;
    logic [AES_BLOCK_W-1:0] result;
    logic [1:0]             out_cnt;
    logic                   key_shift;
    logic                   text_shift;
    logic                   key_full;
    logic                   text_full;
    logic                   state_change;
    logic                   cmd_fire;
    logic                   out_fire;

    // Ready signals depend only on state so the word-count feedback stays acyclic
    assign cmd_ready_o  = (state == ST_IDLE);
    assign in_ready_o   = (state == ST_LOAD_KEY) || (state == ST_LOAD_TEXT);
    assign cmd_fire     = cmd_valid_i && (state == ST_IDLE);
    assign key_shift    = in_valid_i && (state == ST_LOAD_KEY);
    assign text_shift   = in_valid_i && (state == ST_LOAD_TEXT);
    assign out_fire     = out_ready_i && (state == ST_DRAIN);
    assign state_change = (state_next != state);

    assign busy_o     = (state != ST_IDLE);
    assign err_o      = err_q;
    assign out_data_o = result[AES_BLOCK_W-1 -: AES_WORD_W];
    assign out_last_o = (state == ST_DRAIN) && (out_cnt == 2'(AES_WORDS - 1));

    // The packer registers drive the core directly; they only move during the load states
    aes128_word_packer u_key_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_change),
        .shift (key_shift),
        .data  (in_data_i),
        .block (aes_key_o),
        .full  (key_full)
    );

    aes128_word_packer u_text_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_change),
        .shift (text_shift),
        .data  (in_data_i),
        .block (aes_text_o),
        .full  (text_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the output valid and the single start pulse
    always_comb begin
        state_next      = state;
        out_valid_o     = 1'b0;
        aes_start_enc_o = 1'b0;
        aes_start_dec_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_key_i) begin
                        state_next = ST_LOAD_KEY;
                    end else if (key_valid) begin
                        state_next = ST_LOAD_TEXT;
                    end
                end
            end
            ST_LOAD_KEY: begin
                if (key_full) begin
                    state_next = ST_LOAD_TEXT;
                end
            end
            ST_LOAD_TEXT: begin
                if (text_full) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                aes_start_enc_o = aes_ready_i && !dir;
                aes_start_dec_o = aes_ready_i && dir;
                if (aes_ready_i) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (aes_done_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i && (out_cnt == 2'(AES_WORDS - 1))) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command bookkeeping: direction, retained-key flag and the missing-key error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            dir       <= 1'b0;
            key_valid <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (cmd_fire) begin
                dir <= cmd_dec_i;
            end
            if (key_full) begin
                key_valid <= 1'b1;
            end
            err_q <= cmd_fire && !cmd_key_i && !key_valid;
        end
    end

    // Result unpacker: capture on done, then present the top word and shift on each handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            out_cnt <= '0;
        end else begin
            if ((state == ST_WAIT_DONE) && aes_done_i) begin
                result <= aes_text_i;
            end else if (out_fire) begin
                result <= {result[AES_BLOCK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 2'd1;
            end else if (state != ST_DRAIN) begin
                out_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// tb/tb_aes128_stream_ctrl.sv - randomized self-checking bench for aes128_stream_ctrl
module tb_aes128_stream_ctrl;

    localparam logic [127:0] FIPS_K = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_P = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] FIPS_C = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid_i, cmd_ready_o, cmd_dec_i, cmd_key_i;
    logic         in_valid_i, in_ready_o;
    logic [31:0]  in_data_i;
    logic         out_valid_o, out_ready_i, out_last_o;
    logic [31:0]  out_data_o;
    logic         aes_start_enc_o, aes_start_dec_o;
    logic [127:0] aes_key_o, aes_text_o, aes_text_i;
    logic         aes_ready_i, aes_done_i;
    logic         busy_o, err_o;

    aes128_stream_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_dec_i       (cmd_dec_i),
        .cmd_key_i       (cmd_key_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_last_o      (out_last_o),
        .aes_start_enc_o (aes_start_enc_o),
        .aes_start_dec_o (aes_start_dec_o),
        .aes_key_o       (aes_key_o),
        .aes_text_o      (aes_text_o),
        .aes_ready_i     (aes_ready_i),
        .aes_done_i      (aes_done_i),
        .aes_text_i      (aes_text_i),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // model and environment state
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic [127:0] exp_key_q[$];
    logic [127:0] exp_text_q[$];
    logic         exp_dir_q[$];
    logic [127:0] model_key = '0;
    bit           model_key_valid = 0;
    logic         err_expect = 1'b0;
    bit           running = 0;
    bit           gaps_en = 0;
    bit           hold_ready = 0;
    bit           ready_random = 0;
    int           force_lat = 0;
    int           oready_mode = 0;
    int           out_idx = 0;
    int           starts = 0;
    int           start_cyc = 0, done_cyc = 0, first_valid_cyc = 0, last_cyc = 0;
    bit           core_busy = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_k(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in for the cipher core: exact FIPS-197 App. B pair, otherwise an arbitrary keyed mix
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t, input logic dec);
        if (k == FIPS_K && !dec && t == FIPS_P) return FIPS_C;
        if (k == FIPS_K && dec && t == FIPS_C) return FIPS_P;
        return {t[63:0], t[127:64]} ^ k ^ (dec ? 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3 : 128'h0);
    endfunction

    // Core behaviour: goes busy on a start pulse, answers with done after a latency, noise otherwise
    initial begin
        logic         st;
        logic [127:0] ck, ct;
        logic         cd;
        int           lat;
        aes_ready_i = 1'b0;
        aes_done_i  = 1'b0;
        aes_text_i  = '0;
        ck = '0; ct = '0; cd = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            st = aes_start_enc_o | aes_start_dec_o;
            if (st) begin
                ck = aes_key_o;
                ct = aes_text_o;
                cd = aes_start_dec_o;
            end
            @(posedge clk);
            #1;
            aes_done_i = 1'b0;
            aes_text_i = {$urandom, $urandom, $urandom, $urandom};
            if (st) begin
                core_busy   = 1;
                lat         = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
                aes_ready_i = 1'b0;
            end else if (core_busy) begin
                lat--;
                if (lat == 0) begin
                    core_busy  = 0;
                    aes_done_i = 1'b1;
                    aes_text_i = core_fn(ck, ct, cd);
                    done_cyc   = cyc;
                end
            end else begin
                aes_ready_i = !hold_ready && (!ready_random || ($urandom_range(0, 2) != 0));
            end
        end
    end

    // Output sink ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (oready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ~out_ready_i;
                default: out_ready_i = 1'($urandom);
            endcase
        end
    end

    // Compare process: checks every meaningful DUT output against the model on each cycle
    initial begin
        logic        prev_valid;
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (running && !rst) begin
                chk_b("cmd_ready_vs_busy", cmd_ready_o, ~busy_o);
                chk_b("err_pulse", err_o, err_expect);
                if (in_ready_o) chk_b("in_ready_only_when_busy", busy_o, 1'b1);
                if (prev_stall) chk_w("out_hold_while_stalled", out_data_o, prev_data);
                if (out_valid_o) begin
                    if (!prev_valid) first_valid_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk_b("spurious_out_valid", out_valid_o, 1'b0);
                    end else begin
                        chk_w("out_data", out_data_o, exp_q[0]);
                        chk_b("out_last", out_last_o, out_idx == 3);
                        if (out_ready_i) begin
                            got_q.push_back(out_data_o);
                            void'(exp_q.pop_front());
                            if (out_idx == 3) last_cyc = cyc;
                            out_idx = (out_idx + 1) % 4;
                        end
                    end
                end else begin
                    chk_b("out_last_without_valid", out_last_o, 1'b0);
                end
                if (aes_start_enc_o || aes_start_dec_o) begin
                    starts++;
                    start_cyc = cyc;
                    chk_b("start_onehot", aes_start_enc_o & aes_start_dec_o, 1'b0);
                    chk_b("start_needs_ready", aes_ready_i, 1'b1);
                    if (exp_key_q.size() == 0) begin
                        chk_b("spurious_start", aes_start_enc_o | aes_start_dec_o, 1'b0);
                    end else begin
                        chk_b("start_dir", aes_start_dec_o, exp_dir_q[0]);
                        chk_k("start_key", aes_key_o, exp_key_q[0]);
                        chk_k("start_text", aes_text_o, exp_text_q[0]);
                        void'(exp_key_q.pop_front());
                        void'(exp_text_q.pop_front());
                        void'(exp_dir_q.pop_front());
                    end
                end
                prev_valid = out_valid_o;
                prev_stall = out_valid_o & ~out_ready_i;
                prev_data  = out_data_o;
            end else begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) chk_b("idle_timeout", busy_o, 1'b0);
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            if (gaps_en) begin
                in_valid_i = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = blk[127 - 32*i -: 32];
            @(negedge clk);
            while (!in_ready_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk_b("in_ready_timeout", in_ready_o, 1'b1);
            @(posedge clk);
            #1;
            in_valid_i = 1'b0;
            in_data_i  = $urandom;
        end
    endtask

    task automatic do_cmd(input logic dec, input logic key_flag, input logic [127:0] key,
                          input logic [127:0] text, input int stall_start, input bit abort);
        logic [127:0] use_key;
        logic [127:0] res;
        bit           expect_err;
        int           hs_cyc;
        int           starts0;
        int           n;
        wait_idle();
        expect_err = !key_flag && !model_key_valid;
        use_key    = key_flag ? key : model_key;
        starts0    = starts;
        if (!expect_err) begin
            res = core_fn(use_key, text, dec);
            for (int i = 0; i < 4; i++) exp_q.push_back(res[127 - 32*i -: 32]);
            exp_key_q.push_back(use_key);
            exp_text_q.push_back(text);
            exp_dir_q.push_back(dec);
        end
        cmd_valid_i = 1'b1;
        cmd_dec_i   = dec;
        cmd_key_i   = key_flag;
        @(negedge clk);
        chk_b("cmd_ready", cmd_ready_o, 1'b1);
        @(posedge clk);
        #1;
        hs_cyc      = cyc;
        cmd_valid_i = 1'b0;
        cmd_dec_i   = 1'($urandom);
        cmd_key_i   = 1'($urandom);
        if (expect_err) begin
            err_expect = 1'b1;
            @(posedge clk);
            #1;
            err_expect = 1'b0;
            chk_b("err_no_in_ready", in_ready_o, 1'b0);
            chk_b("err_stays_idle", busy_o, 1'b0);
            @(posedge clk);
            #1;
            chk_b("err_no_in_ready_later", in_ready_o, 1'b0);
            return;
        end
        if (key_flag) begin
            send_block(key);
            model_key       = key;
            model_key_valid = 1;
        end
        send_block(text);
        if (stall_start > 0) begin
            repeat (stall_start) begin
                @(negedge clk);
                chk_b("no_start_while_core_busy", aes_start_enc_o | aes_start_dec_o, 1'b0);
                chk_b("held_in_start", busy_o & ~in_ready_o & ~out_valid_o, 1'b1);
            end
            hold_ready = 0;
            @(negedge clk);
            chk_b("start_when_ready_rises", aes_start_enc_o | aes_start_dec_o, 1'b1);
        end
        if (abort) begin
            n = 0;
            while (starts == starts0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk_i("abort_started", starts - starts0, 1);
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            chk_b("abort_in_wait_done", busy_o & ~out_valid_o & ~in_ready_o, 1'b1);
            rst = 1'b1;
            exp_q.delete();
            exp_key_q.delete();
            exp_text_q.delete();
            exp_dir_q.delete();
            out_idx         = 0;
            model_key_valid = 0;
            model_key       = '0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk_b("abort_busy", busy_o, 1'b0);
            chk_b("abort_cmd_ready", cmd_ready_o, 1'b1);
            chk_k("abort_key_cleared", aes_key_o, 128'h0);
            chk_k("abort_text_cleared", aes_text_o, 128'h0);
            return;
        end
        wait_idle();
        chk_i("starts_per_cmd", starts - starts0, 1);
        chk_i("done_to_out_valid", first_valid_cyc - done_cyc, 1);
        if (!gaps_en && !ready_random && stall_start == 0)
            chk_i("cmd_to_start", start_cyc - hs_cyc, key_flag ? 8 : 4);
        if (oready_mode == 0) chk_i("drain_cycles", last_cyc - first_valid_cyc, 3);
    endtask

    task automatic chk_got(input string name, input logic [127:0] lit);
        chk_i({name, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_w(name, (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, lit[127 - 32*i -: 32]);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_dec_i = 1'b0; cmd_key_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk_b("reset_cmd_ready", cmd_ready_o, 1'b1);
        chk_b("reset_busy", busy_o, 1'b0);
        chk_b("reset_in_ready", in_ready_o, 1'b0);
        chk_b("reset_out_valid", out_valid_o, 1'b0);
        chk_b("reset_err", err_o, 1'b0);
        chk_b("reset_start", aes_start_enc_o | aes_start_dec_o, 1'b0);
        chk_k("reset_key", aes_key_o, 128'h0);
        chk_k("reset_text", aes_text_o, 128'h0);
        running = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // text-only command with no key loaded
        do_cmd(1'b0, 1'b0, '0, 128'h1, 0, 0);

        // FIPS-197 App. B encrypt, no stalls
        got_q.delete();
        do_cmd(1'b0, 1'b1, FIPS_K, FIPS_P, 0, 0);
        chk_got("fips_enc_word", 128'h3925841d_02dc09fb_dc118597_196a0b32);

        // decrypt with the retained key
        got_q.delete();
        do_cmd(1'b1, 1'b0, '0, FIPS_C, 0, 0);
        chk_got("fips_dec_word", 128'h3243f6a8_885a308d_313198a2_e0370734);

        // core not ready for 5 cycles in START
        hold_ready = 1;
        do_cmd(1'b0, 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 5, 0);

        // output backpressure with a toggling sink
        oready_mode = 1;
        gaps_en     = 1;
        do_cmd(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 0, 0);

        // randomized traffic
        oready_mode  = 2;
        ready_random = 1;
        for (int k = 0; k < 30; k++) begin
            do_cmd(1'($urandom), ($urandom_range(0, 3) == 0),
                   {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 0, 0);
        end

        // reset while waiting for the core, then a stray done
        ready_random = 0;
        oready_mode  = 0;
        force_lat    = 30;
        do_cmd(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 0, 1);
        n = 0;
        while (core_busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_b("stray_done_delivered", core_busy, 1'b0);
        force_lat = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_b("stray_done_no_valid", out_valid_o, 1'b0);
            chk_b("stray_done_not_busy", busy_o, 1'b0);
        end
        do_cmd(1'b0, 1'b0, '0, 128'h2, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
